inst_loader: RTL and testbench

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/inst_loader.sv | 101 ++++++++++
 tb/tb_inst_loader.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// inst_loader: loads a length-prefixed big-endian byte stream into instruction memory; define LOADER_CHECKSUM_EN for an XOR trailer check
module inst_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [15:0]       word_count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_reset
);
`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR} state_t;
  localparam state_t FIN = CHK;
  logic [7:0] sum;
`else
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, DONE, ERR} state_t;
  localparam state_t FIN = DONE;
`endif
  localparam logic [16:0] MAX = 17'(MAX_WORDS);
  state_t      state;
  logic [23:0] sh;
  logic [1:0]  bcnt;
  logic [15:0] idx;
  logic        acc;
  logic [15:0] len;
  assign acc = byte_valid && byte_ready;
  assign len = {word_count[15:8], byte_in};
`ifdef LOADER_CHECKSUM_EN
  assign busy = state inside {LEN_HI, LEN_LO, DATA, CHK};
`else
  assign busy = state inside {LEN_HI, LEN_LO, DATA};
`endif
  assign byte_ready = busy;
  assign done       = state == DONE;
  assign err        = state == ERR;
  assign cpu_reset  = state != DONE;
  // load sequencer: header parse, word assembly with one write strobe per word, optional trailer check
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      word_count <= '0;
      sh         <= '0;
      bcnt       <= '0;
      idx        <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, DONE, ERR: if (start) begin
          state <= LEN_HI;
          bcnt  <= '0;
          idx   <= '0;
`ifdef LOADER_CHECKSUM_EN
          sum   <= '0;
`endif
        end
        LEN_HI: if (acc) begin
          word_count <= {byte_in, 8'h00};
          state      <= LEN_LO;
        end
        LEN_LO: if (acc) begin
          word_count <= len;
          state      <= {1'b0, len} > MAX ? ERR : (len == 16'd0 ? FIN : DATA);
        end
        DATA: if (acc) begin
          sh   <= {sh[15:0], byte_in};
          bcnt <= bcnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          sum  <= sum ^ byte_in;
`endif
          if (bcnt == 2'd3) begin
            wr_en   <= 1'b1;
            wr_data <= {sh, byte_in};
            wr_addr <= idx[ADDR_W-1:0];
            idx     <= idx + 16'd1;
            if (idx + 16'd1 == word_count) state <= FIN;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHK: if (acc) state <= byte_in == sum ? DONE : ERR;
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: directed streams against a stream-level model of expected writes and final status
module tb_inst_loader;
  logic        clk = 0, reset = 0, start = 0, byte_valid = 0;
  logic [7:0]  byte_in = 0;
  logic        byte_ready, wr_en, busy, done, err, cpu_reset;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [15:0] word_count;

  inst_loader #(.ADDR_W(8), .MAX_WORDS(256)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .word_count(word_count), .busy(busy), .done(done), .err(err), .cpu_reset(cpu_reset));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [7:0]  strm[$];
  logic [39:0] exp_q[$];
  logic [39:0] obs_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // every write strobe must match the next write the model predicts
  always @(negedge clk) begin
    if (reset && wr_en) begin
      obs_q.push_back({wr_addr, wr_data});
      if (exp_q.size() == 0) chk("unexpected_write", {wr_addr, wr_data}, 64'hDEAD);
      else chk("write", {wr_addr, wr_data}, exp_q.pop_front());
    end
  end

  // build a stream: header hdr, nw words (first two given), optional trailer
  task automatic build(input int hdr, input int nw, input logic [31:0] w0, input logic [31:0] w1, input bit bad);
    logic [7:0] x = 0;
    logic [31:0] w;
    strm.delete();
    strm.push_back(8'(hdr >> 8));
    strm.push_back(8'(hdr));
    for (int i = 0; i < nw; i++) begin
      w = i == 0 ? w0 : i == 1 ? w1 : 32'h1000_0000 + 32'(i) * 32'h0103_0507;
      for (int b = 3; b >= 0; b--) begin
        strm.push_back(w[b*8 +: 8]);
        x ^= w[b*8 +: 8];
      end
    end
`ifdef LOADER_CHECKSUM_EN
    if (hdr <= 256) strm.push_back(bad ? 8'h00 : x);
`endif
  endtask

  // model: derive expected writes and outcome from the stream alone
  task automatic predict(output bit ok);
    int n;
    logic [7:0] x = 0;
    logic [31:0] w;
    exp_q.delete();
    n = {strm[0], strm[1]};
    ok = n <= 256;
    if (ok) begin
      for (int i = 0; i < n; i++) begin
        w = {strm[2+4*i], strm[3+4*i], strm[4+4*i], strm[5+4*i]};
        x ^= strm[2+4*i] ^ strm[3+4*i] ^ strm[4+4*i] ^ strm[5+4*i];
        exp_q.push_back({8'(i), w});
      end
`ifdef LOADER_CHECKSUM_EN
      ok = strm[2+4*n] == x;
`endif
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask

  task automatic send(input logic [7:0] b);
    int k = 0;
    byte_in = b;
    byte_valid = 1;
    while (!byte_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!byte_ready) chk("byte_ready_timeout", 0, 1);
    @(negedge clk);
    byte_valid = 0;
  endtask

  task automatic run(input int stall_at);
    bit ok;
    predict(ok);
    obs_q.delete();
    pulse_start();
    foreach (strm[i]) begin
      if (i == stall_at) begin
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          start = k == 4;
        end
        start = 0;
      end
      send(strm[i]);
    end
    repeat (2) @(negedge clk);
    chk("pending_writes", exp_q.size(), 0);
    chk("done", done, ok);
    chk("err", err, !ok);
    chk("cpu_reset", cpu_reset, !ok);
    chk("busy", busy, 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_byte_ready", byte_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cpu_reset", cpu_reset, 1);
  endtask

  initial begin
    bit ok;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    reset = 1;
    @(negedge clk);
    chk("idle_ready", byte_ready, 0);
    // two-word program
    build(2, 2, 32'h20080005, 32'h2009000A, 0);
    run(-1);
    chk("obs_count", obs_q.size(), 2);
    chk("obs0", obs_q[0], {8'h00, 32'h20080005});
    chk("obs1", obs_q[1], {8'h01, 32'h2009000A});
    chk("word_count", word_count, 2);
`ifdef LOADER_CHECKSUM_EN
    build(2, 2, 32'h20080005, 32'h2009000A, 1);
    run(-1);
    chk("bad_trailer_err", err, 1);
`endif
    // oversize header
    build(257, 0, 0, 0, 0);
    run(-1);
    chk("oversize_err", err, 1);
    chk("oversize_nowrites", obs_q.size(), 0);
    // empty program
    build(0, 0, 0, 0, 0);
    run(-1);
    chk("empty_nowrites", obs_q.size(), 0);
    // maximum-length program, address reaches the top
    build(256, 256, 32'hCAFEBABE, 32'h0000_0001, 0);
    run(-1);
    chk("max_count", obs_q.size(), 256);
    chk("max_last_addr", obs_q[255][39:32], 8'hFF);
    // stall mid-word with a start pulse inside DATA
    build(3, 3, 32'h8C0A0004, 32'hFFFF0000, 0);
    run(8);
    chk("stall_obs1", obs_q[1], {8'h01, 32'hFFFF0000});
    // reset after 2 bytes of word 1
    build(2, 2, 32'h20080005, 32'h2009000A, 0);
    predict(ok);
    pulse_start();
    for (int i = 0; i < 8; i++) send(strm[i]);
    #2 reset = 0;
    #1 chk_reset_vals();
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1;
    run(-1);
    chk("reload_count", obs_q.size(), 2);
    chk("reload_addr0", obs_q[0][39:32], 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end
endmodule
